// File: rtl/ad_pkg.sv
// Shared definitions for the multi-channel SAR scan controller.
// Optional build macro: AD_SCAN_AVG_EN (four-conversion averaging per channel).
package ad_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CONV   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Averaging depth: AD_AVG_N conversions, divided by shifting AD_AVG_LOG2
  localparam int AD_AVG_LOG2 = 2;
  localparam int AD_AVG_N    = 4;

endpackage

// File: rtl/ad_sar_step.sv
// Successive-approximation register with bit pointer.
// load presets the MSB trial; step applies one comparator decision and
// raises the next lower trial bit; done flags the LSB decision cycle.
module ad_sar_step #(
  parameter int WIDTH = 8,
  localparam int PW   = $clog2(WIDTH)
) (
  input  logic             adck,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             cmp,
  output logic [WIDTH-1:0] sar,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] lower;

  // Current trial with this cycle's decision applied, plus the next trial bit
  always_comb begin
    result = sar;
    lower  = '0;
    if (!cmp) result[ptr] = 1'b0;
    if (ptr != '0) lower[ptr - 1'b1] = 1'b1;
    done = (ptr == '0);
  end

  // SAR register and pointer; load has priority so a reload can follow a final step
  always_ff @(posedge adck) begin
    if (reset) begin
      sar <= '0;
      ptr <= '0;
    end else if (load) begin
      sar <= {1'b1, {(WIDTH-1){1'b0}}};
      ptr <= PW'(WIDTH-1);
    end else if (step) begin
      sar <= result | lower;
      if (ptr != '0) ptr <= ptr - 1'b1;
    end
  end

endmodule

// File: rtl/ad_scan_sar.sv
// Multi-channel successive-approximation ADC scan controller.
// Scans channels 0..NCH-1, one result per channel with a valid strobe,
// single-scan or continuous. Optional build macro: AD_SCAN_AVG_EN, which
// averages four back-to-back conversions per channel after one settle.
module ad_scan_sar
  import ad_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCH    = 4,
  parameter int SETTLE = 2,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             adck,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             cmp,
  output logic [CHW-1:0]   mux_sel,
  output logic [WIDTH-1:0] dac,
  output logic [WIDTH-1:0] out,
  output logic [CHW-1:0]   out_ch,
  output logic             valid,
  output logic             busy
);

  localparam int SW = $clog2(SETTLE + 1);

  state_t           state, state_nx;
  logic [CHW-1:0]   ch;
  logic [SW-1:0]    settle_cnt;
  logic             load, step, sar_done, conv_last;
  logic [WIDTH-1:0] sar, result, final_val;

  ad_sar_step #(.WIDTH(WIDTH)) u_sar (
    .adck   (adck),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .cmp    (cmp),
    .sar    (sar),
    .result (result),
    .done   (sar_done)
  );

`ifdef AD_SCAN_AVG_EN
  logic [AD_AVG_LOG2-1:0] rep;
  logic [WIDTH+1:0]       acc, sum;

  // Running sum including the conversion finishing this cycle
  always_comb begin
    sum       = acc + {2'b00, result};
    final_val = sum[WIDTH+1:AD_AVG_LOG2];
    conv_last = sar_done && (rep == AD_AVG_LOG2'(AD_AVG_N - 1));
  end

  // Accumulator and conversion counter, cleared while the mux settles
  always_ff @(posedge adck) begin
    if (reset || state == ST_SETTLE) begin
      acc <= '0;
      rep <= '0;
    end else if (state == ST_CONV && sar_done) begin
      acc <= sum;
      rep <= rep + 1'b1;
    end
  end
`else
  // Single conversion: the SAR result is the channel result
  always_comb begin
    final_val = result;
    conv_last = sar_done;
  end
`endif

  // Next-state and SAR control
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      ST_IDLE:   if (start || cont) state_nx = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SW'(SETTLE - 1)) begin
                   state_nx = ST_CONV;
                   load     = 1'b1;
                 end
      ST_CONV: begin
        step = 1'b1;
        if (conv_last)     state_nx = ST_DONE;
        else if (sar_done) load     = 1'b1;
      end
      ST_DONE:   state_nx = (ch != CHW'(NCH - 1) || cont) ? ST_SETTLE : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge adck) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Channel counter and settle counter
  always_ff @(posedge adck) begin
    if (reset) begin
      ch         <= '0;
      settle_cnt <= '0;
    end else begin
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      if (state == ST_IDLE && state_nx == ST_SETTLE)
        ch <= '0;
      else if (state == ST_DONE && state_nx == ST_SETTLE)
        ch <= (ch == CHW'(NCH - 1)) ? '0 : ch + 1'b1;
    end
  end

  // Registered result, strobe and busy; valid is high exactly while in DONE
  always_ff @(posedge adck) begin
    if (reset) begin
      out    <= '0;
      out_ch <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= (state == ST_CONV) && conv_last;
      busy  <= (state_nx != ST_IDLE);
      if (state == ST_CONV && conv_last) begin
        out    <= final_val;
        out_ch <= ch;
      end
    end
  end

  assign mux_sel = ch;
  assign dac     = (state == ST_CONV) ? sar : '0;

endmodule

// File: tb/tb_ad_scan_sar.sv
// Self-checking bench for ad_scan_sar with default parameters.
// Cycle k label = the negedge just before rising edge k; edge 0 samples start.
module tb_ad_scan_sar;

  logic       adck = 1'b0;
  logic       reset, start, cont, cmp;
  logic [1:0] mux_sel, out_ch;
  logic [7:0] dac, out;
  logic       valid, busy;

  ad_scan_sar dut (
    .adck(adck), .reset(reset), .start(start), .cont(cont), .cmp(cmp),
    .mux_sel(mux_sel), .dac(dac), .out(out), .out_ch(out_ch),
    .valid(valid), .busy(busy)
  );

  // Clock
  always #5 adck = ~adck;

  // Analog model
  logic [7:0] vin [4];
  logic [7:0] vin_eff;
  int         cur_k;
  always_comb begin
    vin_eff = vin[mux_sel];
`ifdef AD_SCAN_AVG_EN
    if (mux_sel == 2'd0 && cur_k >= 3)
      vin_eff = (((cur_k - 3) / 8) % 2 == 1) ? 8'h11 : 8'h10;
`endif
  end
  assign cmp = (vin_eff >= dac);

  // Scoreboard: entries are {cycle[15:0], 6'b0, ch[1:0], out[7:0]}
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int pulse_a, pulse_b, cont_off_at, rst_at, busy_hi_at, busy_lo_at;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_cfg();
    pulse_a = -1; pulse_b = -1; cont_off_at = -1; rst_at = -1;
    busy_hi_at = -1; busy_lo_at = -1;
  endtask

  task automatic push_exp(input int cyc, input int ch, input logic [7:0] val);
    logic [15:0] c16;
    logic [1:0]  c2;
    c16 = 16'(cyc);
    c2  = 2'(ch);
    exp_q.push_back({c16, 6'd0, c2, val});
  endtask

  // One full scan of the table {00, FF, 80, 5A} starting at offset base
  task automatic push_scan(input int base);
    push_exp(base + 11, 0, 8'h00);
    push_exp(base + 22, 1, 8'hFF);
    push_exp(base + 33, 2, 8'h80);
    push_exp(base + 44, 3, 8'h5A);
  endtask

  task automatic compare_obs(input string name);
    logic [31:0] g, e;
    check_eq({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front();
      e = exp_q.pop_front();
      check_eq({name, "_valid"}, g, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // mode 0: start, 1: cont only, 2: start+cont for one cycle
  task automatic run_scan(input int mode, input int n);
    logic [15:0] k16;
    @(negedge adck);
    cur_k = 0;
    start = (mode != 1);
    cont  = (mode != 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge adck);
      cur_k = k;
      if (valid) begin
        k16 = 16'(k);
        obs_q.push_back({k16, 6'd0, out_ch, out});
      end
      if (k == busy_hi_at) check_eq("busy_hi", 32'(busy), 32'd1);
      if (k == busy_lo_at) check_eq("busy_lo", 32'(busy), 32'd0);
      if (rst_at > 0 && k == rst_at + 1) begin
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_out_ch", 32'(out_ch), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_dac", 32'(dac), 32'd0);
        check_eq("rst_mux", 32'(mux_sel), 32'd0);
        reset = 1'b0;
      end
      start = (k == pulse_a || k == pulse_b);
      if (mode == 2 && k == 1) cont = 1'b0;
      if (k == cont_off_at) cont = 1'b0;
      if (k == rst_at) reset = 1'b1;
    end
    start = 1'b0;
    cont  = 1'b0;
  endtask

  initial begin
    vin[0] = 8'h00; vin[1] = 8'hFF; vin[2] = 8'h80; vin[3] = 8'h5A;
    cur_k = 0;
    reset = 1'b1; start = 1'b0; cont = 1'b0;
    clear_cfg();

    // Reset: two cycles, then all outputs zero
    repeat (2) @(posedge adck);
    @(negedge adck);
    check_eq("reset_out", 32'(out), 32'd0);
    check_eq("reset_out_ch", 32'(out_ch), 32'd0);
    check_eq("reset_valid", 32'(valid), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_dac", 32'(dac), 32'd0);
    check_eq("reset_mux", 32'(mux_sel), 32'd0);
    reset = 1'b0;
    @(negedge adck);

`ifdef AD_SCAN_AVG_EN
    // Averaging: (10+11+10+11)>>2 = 0x10 on channel 0 at cycle 35
    clear_cfg();
    busy_hi_at = 35;
    push_exp(35, 0, 8'h10);
    run_scan(0, 40);
    compare_obs("avg");
`else
    // Single scan
    clear_cfg();
    busy_hi_at = 44; busy_lo_at = 45;
    push_scan(0);
    run_scan(0, 50);
    compare_obs("single");

    // Start and cont together for one cycle: same as start alone
    clear_cfg();
    busy_hi_at = 44; busy_lo_at = 45;
    push_scan(0);
    run_scan(2, 50);
    compare_obs("start_cont");

    // Continuous, cont dropped during channel 1 of the second scan
    clear_cfg();
    cont_off_at = 60; busy_hi_at = 88; busy_lo_at = 89;
    push_scan(0);
    push_scan(44);
    run_scan(1, 100);
    compare_obs("continuous");

    // Start while busy is ignored
    clear_cfg();
    pulse_a = 5; pulse_b = 20; busy_lo_at = 45;
    push_scan(0);
    run_scan(0, 70);
    compare_obs("start_busy");
    check_eq("start_busy_idle", 32'(busy), 32'd0);

    // Reset mid-conversion: no valid, outputs cleared
    clear_cfg();
    rst_at = 6;
    run_scan(0, 30);
    compare_obs("reset_mid");

    // Fresh scan after reset
    clear_cfg();
    busy_lo_at = 45;
    push_scan(0);
    run_scan(0, 50);
    compare_obs("after_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
